alu_core: RTL and testbench
===========================

# alu_core

Registered 32-bit ALU for the RISC datapath's execute stage. It combines four units: an adder/subtractor with Z/V/N flags, a signed comparator, a truth-table boolean unit and a barrel shifter. All four evaluate every operand pair in parallel; `alufn[5:4]` selects which result is registered. Operands are accepted with a valid strobe, and one registered result is produced per accepted operation.

## Interface
- `WIDTH`, 32: datapath width; only 32 is supported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all registers.
- `in_valid`  in  1  operands and opcode are valid this cycle.
- `alufn`  in  6  operation code.
- `a`  in  32  operand A.
- `b`  in  32  operand B; its low 5 bits are the shift amount.
- `out_valid`  out  1  `result` and flags hold a new operation.
- `result`  out  32  selected unit output.
- `z`  out  1  adder output is zero.
- `v`  out  1  adder signed overflow.
- `n`  out  1  adder output bit 31.

## Operation
- **Adder.** `xb = b ^ {32{alufn[0]}}`; `s = a + xb + alufn[0]` mod 2^32. `alufn[0]=0` gives A+B; `alufn[0]=1` gives A−B.
- **Flags**, always derived from `s`, whatever unit is selected:
  - `z = (s==0)`
  - `n = s[31]`
  - `v = (a[31] & xb[31] & ~s[31]) | (~a[31] & ~xb[31] & s[31])`
- **Comparator.** Has its own internal a−b, independent of `alufn[0]`, with flags zc/vc/nc computed the same way. `alufn[2:1]` selects the test:
  - 01 CMPEQ: `zc`
  - 10 CMPLT: `nc^vc`
  - 11 CMPLE: `zc|(nc^vc)`
  - 00: 0
  - Output is `{31'b0, bit}`.
- **Boolean unit.** Bitwise: `res[i] = alufn[{b[i],a[i]}]`, with `alufn[3:0]` as a truth table. Examples: AND=1000, OR=1110, XOR=0110, "A"=1010.
- **Shifter.** Shift amount is `b[4:0]`; `alufn[1:0]` selects the operation:
  - 00 SHL: a << sh
  - 01 SHR: logical right shift
  - 11 SRA: arithmetic right shift, sign-filling from a[31]
  - 10: same as SHL
- **Result select**, by `alufn[5:4]`: 00 adder, 01 boolean, 10 shifter, 11 comparator.
- Canonical codes:
  - ADD 000000, SUB 000001
  - AND 011000, OR 011110, XOR 010110, A 011010
  - SHL 100000, SHR 100001, SRA 100011
  - CMPEQ 110011, CMPLT 110101, CMPLE 110111
- No exceptions or traps; overflow is reported only through `v`.

## Timing
- Latency is 1 cycle. On a rising edge with `in_valid=1`, the selected result and z/v/n are registered and `out_valid` is set to 1 in the same edge.
- `out_valid` is always `in_valid` delayed by one cycle; back-to-back operations give one result per cycle.
- With `in_valid=0`, `result` and the flags hold their last values and `out_valid` drops to 0 on the next edge.
- The combinational path from `a`/`b`/`alufn` to the register inputs is a single cycle; there are no internal pipeline stages.
- Reset, asserted at any time, immediately forces `result=0`, `z=0`, `v=0`, `n=0` and `out_valid=0`. An operation accepted in the cycle reset asserts is dropped.
- After reset deasserts, the first rising edge with `in_valid=1` produces a valid result one cycle later.

## Test plan
- **ADD/SUB.**
  - ADD 7FFFFFFF + 00000001 → result 80000000, v=1, n=1, z=0.
  - SUB FFFFFFFF − FFFFFFFF → 00000000, z=1, v=0.
  - SUB FFFFFFF2 − FFFFFFF0 → 00000002.
  - SUB 80000000 − 7FFFFFFF → 00000001, v=1.
- **Compares.**
  - a=00000002, b=FFFFFFFD: CMPEQ/LT/LE → 0/0/0.
  - a=80000000, b=12345678: CMPLE → 1.
  - a=b=00000003: CMPEQ/LT/LE → 1/0/1.
  - a=00000003, b=00000005: CMPLT → 1.
- **Boolean**, a=FFFFFFFF, b=00000000:
  - AND → 0
  - OR → FFFFFFFF
  - XOR → FFFFFFFF
  - A → FFFFFFFF
  - a=b=FFFFFFFF, XOR → 0.
- **Shifts**, a=80000001:
  - SHL by 4 → 00000010
  - SHR by 4 → 08000000
  - SRA by 4 → F8000000
  - shift by b=00000020 (amount 0) → a unchanged.
- **Handshake.**
  - Three back-to-back valid ops → three results on consecutive cycles, each one cycle after its input.
  - An `in_valid` gap → `out_valid` low for one cycle, `result` held.
- **Reset.** Assert reset mid-stream between clock edges → outputs and `out_valid` go 0 immediately, before the next edge, and stay 0 until a new valid op follows deassertion.

Source files
------------

// File: rtl/alu_core.sv
// alu_core: registered ALU for the execute stage.
// The adder, comparator, boolean unit and shifter all evaluate in parallel.
// alufn[5:4] picks which result is registered. The z/v/n flags always come
// from the adder, whichever unit is selected.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [5:0]       alufn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             v,
    output logic             n
);
    localparam int SHW = $clog2(WIDTH);

    // adder / subtractor
    logic [WIDTH-1:0] xb, s;
    logic             s_z, s_v, s_n;

    // comparator keeps its own a-b so it does not depend on alufn[0]
    logic [WIDTH-1:0] sc;
    logic             zc, vc, nc, cmp_bit;
    logic [WIDTH-1:0] cmp_res;

    // boolean unit and shifter
    logic [WIDTH-1:0] bool_res;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] shl, shr, sra, shf_res;

    logic [WIDTH-1:0] sel_res;

    assign xb  = b ^ {WIDTH{alufn[0]}};
    assign s   = a + xb + {{(WIDTH-1){1'b0}}, alufn[0]};
    assign s_z = (s == '0);
    assign s_n = s[WIDTH-1];
    assign s_v = (a[WIDTH-1] & xb[WIDTH-1] & ~s[WIDTH-1]) |
                 (~a[WIDTH-1] & ~xb[WIDTH-1] & s[WIDTH-1]);

    assign sc  = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    assign zc  = (sc == '0);
    assign nc  = sc[WIDTH-1];
    assign vc  = (a[WIDTH-1] & ~b[WIDTH-1] & ~sc[WIDTH-1]) |
                 (~a[WIDTH-1] & b[WIDTH-1] & sc[WIDTH-1]);

    // each result bit looks up alufn[3:0] as a truth table indexed by {b,a}
    for (genvar i = 0; i < WIDTH; i++) begin : g_bool
        assign bool_res[i] = alufn[{b[i], a[i]}];
    end

    assign sh  = b[SHW-1:0];
    assign shl = a << sh;
    assign shr = a >> sh;
    assign sra = $signed(a) >>> sh;

    // pick the compare test; code 00 yields 0
    always_comb begin
        cmp_bit = 1'b0;
        case (alufn[2:1])
            2'b01:   cmp_bit = zc;
            2'b10:   cmp_bit = nc ^ vc;
            2'b11:   cmp_bit = zc | (nc ^ vc);
            default: cmp_bit = 1'b0;
        endcase
    end

    assign cmp_res = {{(WIDTH-1){1'b0}}, cmp_bit};

    // pick the shift; code 10 falls back to a left shift
    always_comb begin
        shf_res = shl;
        case (alufn[1:0])
            2'b01:   shf_res = shr;
            2'b11:   shf_res = sra;
            default: shf_res = shl;
        endcase
    end

    // unit select on alufn[5:4]
    always_comb begin
        sel_res = s;
        case (alufn[5:4])
            2'b00:   sel_res = s;
            2'b01:   sel_res = bool_res;
            2'b10:   sel_res = shf_res;
            default: sel_res = cmp_res;
        endcase
    end

    // output register: capture on valid, hold otherwise, async clear on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            z         <= 1'b0;
            v         <= 1'b0;
            n         <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= sel_res;
                z      <= s_z;
                v      <= s_v;
                n      <= s_n;
            end
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors for alu_core, checked through a scoreboard.
// The stimulus side pushes hand-computed expectations into a queue.
// The monitor pops one expectation for every out_valid beat and compares.
module tb_alu_core;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [5:0]  alufn;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] result;
    logic        z, v, n;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        chk_flags;
        logic        ez, ev, en;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   ncmp  = 0;
    int   nfail = 0;
    int   cyc   = 0;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001;
    localparam logic [5:0] AND = 6'b011000, OR = 6'b011110, XOR = 6'b010110, PA = 6'b011010;
    localparam logic [5:0] SHL = 6'b100000, SHR = 6'b100001, SRA = 6'b100011;
    localparam logic [5:0] CEQ = 6'b110011, CLT = 6'b110101, CLE = 6'b110111;

    alu_core #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alufn(alufn),
        .a(a), .b(b), .out_valid(out_valid), .result(result),
        .z(z), .v(v), .n(n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [5:0] fn, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] ex, input logic cf,
                         input logic ez, input logic ev, input logic en);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; alufn = fn; a = aa; b = bb;
        e.name = nm; e.res = ex; e.chk_flags = cf;
        e.ez = ez; e.ev = ev; e.en = en; e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, {31'b0, out_valid}, 32'd0);
        chk({nm, "_result"}, result, 32'd0);
        chk({nm, "_flags"}, {29'b0, z, v, n}, 32'd0);
    endtask

    // monitor: every out_valid beat must match the oldest pending expectation
    always begin
        @(posedge clk);
        #1;
        if (out_valid) begin
            if (sb.size() == 0) begin
                ncmp++; nfail++;
                $display("FAIL unexpected_out: result %08h with no pending op", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.name, result, e.res);
                chk({e.name, "_latency"}, cyc, e.cyc);
                if (e.chk_flags)
                    chk({e.name, "_zvn"}, {29'b0, z, v, n}, {29'b0, e.ez, e.ev, e.en});
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; alufn = '0; a = '0; b = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // back-to-back stream: every op is checked one cycle after it is issued
        issue("add_ovf",  ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 0, 1, 1);
        issue("sub_zero", SUB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 1, 0, 0);
        issue("sub_neg",  SUB, 32'hFFFFFFF2, 32'hFFFFFFF0, 32'h00000002, 1, 0, 0, 0);
        issue("sub_ovf",  SUB, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1, 0, 1, 0);
        issue("ceq_2_m3", CEQ, 32'h00000002, 32'hFFFFFFFD, 32'h0, 0, 0, 0, 0);
        issue("clt_2_m3", CLT, 32'h00000002, 32'hFFFFFFFD, 32'h0, 0, 0, 0, 0);
        issue("cle_2_m3", CLE, 32'h00000002, 32'hFFFFFFFD, 32'h0, 0, 0, 0, 0);
        issue("cle_min",  CLE, 32'h80000000, 32'h12345678, 32'h1, 0, 0, 0, 0);
        // flags follow the adder (a-b=0) even though the comparator is selected
        issue("ceq_3_3",  CEQ, 32'h00000003, 32'h00000003, 32'h1, 1, 1, 0, 0);
        issue("clt_3_3",  CLT, 32'h00000003, 32'h00000003, 32'h0, 0, 0, 0, 0);
        issue("cle_3_3",  CLE, 32'h00000003, 32'h00000003, 32'h1, 0, 0, 0, 0);
        issue("clt_3_5",  CLT, 32'h00000003, 32'h00000005, 32'h1, 0, 0, 0, 0);
        issue("and",      AND, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 0, 0, 0, 0);
        issue("or",       OR,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0);
        issue("xor",      XOR, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0);
        issue("pass_a",   PA,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0);
        issue("xor_same", XOR, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 0, 0, 0);
        issue("shl4",     SHL, 32'h80000001, 32'h00000004, 32'h00000010, 0, 0, 0, 0);
        issue("shr4",     SHR, 32'h80000001, 32'h00000004, 32'h08000000, 0, 0, 0, 0);
        issue("sra4",     SRA, 32'h80000001, 32'h00000004, 32'hF8000000, 0, 0, 0, 0);
        issue("shl32",    SHL, 32'h80000001, 32'h00000020, 32'h80000001, 0, 0, 0, 0);
        issue("sra32",    SRA, 32'h80000001, 32'h00000020, 32'h80000001, 0, 0, 0, 0);

        // an in_valid gap: out_valid drops for one cycle while result holds
        issue("gap_pre",  ADD, 32'h00000001, 32'h00000002, 32'h00000003, 1, 0, 0, 0);
        idle();
        @(posedge clk); #1;
        chk("gap_valid", {31'b0, out_valid}, 32'd0);
        chk("gap_hold", result, 32'h00000003);
        issue("gap_post", ADD, 32'h00000010, 32'h00000020, 32'h00000030, 1, 0, 0, 0);

        // reset between edges clears the outputs at once
        issue("pre_rst",  SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1, 0, 0, 1);
        idle();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk_zero("async_rst");
        // an op offered while reset is held is dropped, so nothing is queued for it
        @(negedge clk);
        in_valid = 1'b1; alufn = ADD; a = 32'h5; b = 32'h5;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk_zero("post_rst");
        issue("after_rst", ADD, 32'h00000005, 32'h00000005, 32'h0000000A, 1, 0, 0, 0);
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk); #2;
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
        $finish;
    end
endmodule
